// File: rtl/decoder_scan_seq_if.sv
// Select-sequencer bus: control inputs from the controller, registered selects back.
interface decoder_scan_seq_if #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_OUT = 32,
    parameter int unsigned DWELL_W = 8
);
    logic               enable;
    logic [1:0]         mode;
    logic               load;
    logic [ADDR_W-1:0]  A;
    logic [DWELL_W-1:0] dwell;
    logic [NUM_OUT-1:0] Dout;
    logic [ADDR_W-1:0]  cur_addr;
    logic               valid;
    logic               wrap;
    logic               done;

    modport master (
        output enable, mode, load, A, dwell,
        input  Dout, cur_addr, valid, wrap, done
    );

    modport slave (
        input  enable, mode, load, A, dwell,
        output Dout, cur_addr, valid, wrap, done
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Registered one-hot decoder with direct, scan-up, scan-down and single-sweep sequencing,
// each address held for dwell+1 cycles.
module decoder_scan_seq #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_OUT = 32,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder_scan_seq_if.slave  bus
);
    localparam int unsigned       LAST   = NUM_OUT - 1;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST);

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_UP     = 2'b01;
    localparam logic [1:0] M_DOWN   = 2'b10;
    localparam logic [1:0] M_SWEEP  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [NUM_OUT-1:0] dout_q;
    logic               valid_q;
    logic               wrap_q;
    logic               done_q;

    logic [ADDR_W-1:0]  adv_addr;
    logic               adv_wrap;
    logic               adv_end;

    // Out-of-range addresses decode to all-zero.
    function automatic logic [NUM_OUT-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (32'(a) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Next address when the dwell expires in the current mode.
    always_comb begin
        adv_addr = addr_q;
        adv_wrap = 1'b0;
        adv_end  = 1'b0;
        case (mode_q)
            M_UP: begin
                if (32'(addr_q) >= LAST) begin
                    adv_addr = '0;
                    adv_wrap = 1'b1;
                end else begin
                    adv_addr = addr_q + ADDR_W'(1);
                end
            end
            M_DOWN: begin
                if (addr_q == '0) begin
                    adv_addr = LAST_A;
                    adv_wrap = 1'b1;
                end else if (32'(addr_q) > LAST) begin
                    adv_addr = LAST_A;
                end else begin
                    adv_addr = addr_q - ADDR_W'(1);
                end
            end
            M_SWEEP: begin
                if (addr_q == LAST_A) begin
                    adv_end = 1'b1;
                end else if (32'(addr_q) > LAST) begin
                    adv_addr = '0;
                end else begin
                    adv_addr = addr_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Sequencer state and registered selects; disable freezes everything but blanks outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= M_DIRECT;
            addr_q    <= '0;
            dwell_cnt <= '0;
            dwell_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (!bus.enable) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            mode_q <= bus.mode;
            if (bus.load) begin
                state     <= ST_RUN;
                addr_q    <= bus.A;
                dwell_cnt <= '0;
                dwell_q   <= bus.dwell;
                done_q    <= 1'b0;
                dout_q    <= onehot(bus.A);
                valid_q   <= |onehot(bus.A);
            end else if (state == ST_RUN) begin
                if (bus.mode != mode_q) begin
                    dwell_cnt <= '0;
                    dout_q    <= onehot(addr_q);
                    valid_q   <= |onehot(addr_q);
                end else if (mode_q == M_DIRECT || dwell_cnt != dwell_q) begin
                    if (mode_q != M_DIRECT) dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    dout_q  <= onehot(addr_q);
                    valid_q <= |onehot(addr_q);
                end else if (adv_end) begin
                    state     <= ST_DONE;
                    done_q    <= 1'b1;
                    dwell_cnt <= '0;
                    dout_q    <= '0;
                    valid_q   <= 1'b0;
                end else begin
                    addr_q    <= adv_addr;
                    wrap_q    <= adv_wrap;
                    dwell_cnt <= '0;
                    dwell_q   <= bus.dwell;
                    dout_q    <= onehot(adv_addr);
                    valid_q   <= |onehot(adv_addr);
                end
            end else begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.Dout     = dout_q;
    assign bus.cur_addr = addr_q;
    assign bus.valid    = valid_q;
    assign bus.wrap     = wrap_q;
    assign bus.done     = done_q;
endmodule
